// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the parametrised sequence detector
package seq_det_pkg;
  typedef enum logic {NON_OVERLAP = 1'b0, OVERLAP = 1'b1} mode_e;
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
  function automatic int clamp_len(input int len, input int pat_w);
    return len < 1 ? 1 : len > pat_w ? pat_w : len;
  endfunction
endpackage

// File: rtl/seq_det_match_cnt.sv
// seq_det_match_cnt: saturating match counter with synchronous clear
module seq_det_match_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable Mealy serial-pattern detector with match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(4'b1101),
  parameter int CNT_W = 8,
  localparam int LW = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [PAT_W-1:0] pattern_q,
  output logic [LW-1:0]    len_q
);
  logic [PAT_W-1:0] hist_q, hist_d, pattern_d, seq, mask;
  logic [LW-1:0] fill_q, fill_d, len_d;
  mode_e overlap_q, overlap_d;
  logic take;
  always_comb begin
    seq = {hist_q[PAT_W-2:0], in};
    mask = ~({PAT_W{1'b1}} << len_q);
    take = in_valid && !cfg_load && !reset;
    out = take && (int'(fill_q) >= int'(len_q) - 1) && (((seq ^ pattern_q) & mask) == '0);
    hist_d = take ? seq : hist_q;
    fill_d = cfg_load ? '0 : !take ? fill_q : (out && overlap_q == NON_OVERLAP) ? '0 :
             fill_q == LW'(PAT_W) ? fill_q : fill_q + LW'(1);
    pattern_d = cfg_load ? cfg_pattern : pattern_q;
    len_d = cfg_load ? LW'(clamp_len(int'(cfg_len), PAT_W)) : len_q;
    overlap_d = cfg_load ? mode_e'(cfg_overlap) : overlap_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pattern_q <= PAT_DEFAULT;
      len_q <= LW'(PAT_W);
      overlap_q <= OVERLAP;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pattern_q <= pattern_d;
      len_q <= len_d;
      overlap_q <= overlap_d;
    end
  end
  seq_det_match_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr(cnt_clr),
    .inc(out),
    .count(match_count)
  );
endmodule
